// File: rtl/cobs_frame_fifo_pkg.sv
// -----------------------------------------------------------------------------
// cobs_package
// Shared definitions for the COBS frame FIFO: the byte width, the frame
// delimiter value, the byte type, the accept/drop state encoding and a small
// helper that recognises the delimiter.
// No ports (package).
// -----------------------------------------------------------------------------
package cobs_package;

  localparam int COBS_BYTE_WIDTH = 8;

  typedef logic [COBS_BYTE_WIDTH-1:0] cobs_byte_t;

  localparam cobs_byte_t COBS_DELIMITER = 8'h00;

  typedef enum logic [0:0] {
    COBS_FIFO_ACCEPT = 1'b0,
    COBS_FIFO_DROP   = 1'b1
  } cobs_fifo_state_t;

  // True when the byte closes a COBS frame.
  function automatic logic cobs_is_delim(input cobs_byte_t b);
    return (b == COBS_DELIMITER);
  endfunction

endpackage

// File: rtl/cobs_frame_fifo_ram.sv
// -----------------------------------------------------------------------------
// cobs_fifo_ram
// DEPTH x 8 storage for the frame FIFO: one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset; validity of
// each location is tracked by the pointers in the parent.
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write byte
//   raddr  in   read address
//   rdata  out  byte at raddr (combinational)
// -----------------------------------------------------------------------------
module cobs_fifo_ram
  import cobs_package::*;
#(
  parameter int DEPTH = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [COBS_BYTE_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]          raddr,
  output logic [COBS_BYTE_WIDTH-1:0] rdata
);

  cobs_byte_t mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/cobs_frame_fifo.sv
// -----------------------------------------------------------------------------
// cobs_frame_fifo
// Frame-aware byte FIFO for a COBS packet stream. Bytes are written
// speculatively at wr_ptr; only when the 0x00 delimiter lands is commit_ptr
// advanced, so the reader (bounded by commit_ptr) never sees a partial frame.
// A frame that hits a full buffer is rewound to commit_ptr and the rest of it
// is swallowed until its delimiter. The input is never back-pressured.
//
// Optional feature macro: COBS_FRAME_FIFO_STATS_EN
//   defined   -> frames_committed / frames_discarded are 16-bit saturating
//                counters, cleared only by reset
//   undefined -> both outputs tied to zero, no counter logic
//
// Ports:
//   clk              in   system clock
//   reset_n          in   asynchronous active-low reset
//   s_axis_tdata     in   COBS byte from the packetizer
//   s_axis_tvalid    in   input byte valid
//   s_axis_tready    out  high at all times out of reset
//   m_axis_tdata     out  committed byte to the transmitter
//   m_axis_tvalid    out  committed byte available
//   m_axis_tready    in   transmitter accepts byte
//   m_axis_tlast     out  current output byte is the delimiter
//   frame_dropped    out  one-cycle pulse per discarded frame
//   frames_pending   out  whole frames committed but not fully read
//   frames_committed out  statistics (see macro above)
//   frames_discarded out  statistics (see macro above)
// -----------------------------------------------------------------------------
module cobs_frame_fifo
  import cobs_package::*;
#(
  parameter int DEPTH = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [COBS_BYTE_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [COBS_BYTE_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       frame_dropped,
  output logic [ADDR_W:0]            frames_pending,
  output logic [15:0]                frames_committed,
  output logic [15:0]                frames_discarded
);

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_P   = (ADDR_W+1)'(1);

  logic [ADDR_W:0]  wr_ptr_r;
  logic [ADDR_W:0]  commit_ptr_r;
  logic [ADDR_W:0]  rd_ptr_r;
  cobs_fifo_state_t state_r;
  logic             s_ready_r;
  logic             drop_r;
  logic [ADDR_W:0]  pending_r;

  logic [ADDR_W:0]  wr_ptr_n;
  logic [ADDR_W:0]  commit_ptr_n;
  cobs_fifo_state_t state_n;
  logic [ADDR_W:0]  pending_n;
  logic             we_s;
  logic             commit_s;
  logic             drop_s;

  logic             in_fire_s;
  logic             in_delim_s;
  logic             full_s;
  logic             out_valid_s;
  logic             out_last_s;
  logic             read_last_s;
  cobs_byte_t       rd_data_s;

  assign in_fire_s   = s_axis_tvalid && s_ready_r;
  assign in_delim_s  = cobs_is_delim(s_axis_tdata);
  // Full is measured against rd_ptr, not commit_ptr: uncommitted bytes of the
  // frame being written occupy real storage.
  assign full_s      = ((wr_ptr_r - rd_ptr_r) == DEPTH_P);
  assign out_valid_s = (rd_ptr_r != commit_ptr_r);
  assign out_last_s  = out_valid_s && cobs_is_delim(rd_data_s);
  assign read_last_s = out_valid_s && m_axis_tready && out_last_s;

  cobs_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_ptr_r[ADDR_W-1:0]),
    .wdata (s_axis_tdata),
    .raddr (rd_ptr_r[ADDR_W-1:0]),
    .rdata (rd_data_s)
  );

  // Write-side next state: speculative store, commit on delimiter, rewind on overflow.
  always_comb begin
    wr_ptr_n     = wr_ptr_r;
    commit_ptr_n = commit_ptr_r;
    state_n      = state_r;
    we_s         = 1'b0;
    commit_s     = 1'b0;
    drop_s       = 1'b0;
    if (in_fire_s) begin
      case (state_r)
        COBS_FIFO_ACCEPT: begin
          if (!full_s) begin
            we_s     = 1'b1;
            wr_ptr_n = wr_ptr_r + ONE_P;
            if (in_delim_s) begin
              commit_ptr_n = wr_ptr_r + ONE_P;
              commit_s     = 1'b1;
            end else begin
              commit_ptr_n = commit_ptr_r;
            end
          end else begin
            // Discard the partial frame; an overflowing delimiter ends it at once.
            wr_ptr_n = commit_ptr_r;
            drop_s   = 1'b1;
            if (in_delim_s) begin
              state_n = COBS_FIFO_ACCEPT;
            end else begin
              state_n = COBS_FIFO_DROP;
            end
          end
        end
        COBS_FIFO_DROP: begin
          if (in_delim_s) begin
            state_n = COBS_FIFO_ACCEPT;
          end else begin
            state_n = COBS_FIFO_DROP;
          end
        end
        default: begin
          wr_ptr_n = commit_ptr_r;
          state_n  = COBS_FIFO_ACCEPT;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Pending-frame count; a commit and a delimiter read in the same cycle cancel.
  always_comb begin
    pending_n = pending_r;
    case ({commit_s, read_last_s})
      2'b10:   pending_n = pending_r + ONE_P;
      2'b01:   pending_n = pending_r - ONE_P;
      default: pending_n = pending_r;
    endcase
  end

  // Pointer, state and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r     <= '0;
      commit_ptr_r <= '0;
      rd_ptr_r     <= '0;
      state_r      <= COBS_FIFO_ACCEPT;
      s_ready_r    <= 1'b0;
      drop_r       <= 1'b0;
      pending_r    <= '0;
    end else begin
      wr_ptr_r     <= wr_ptr_n;
      commit_ptr_r <= commit_ptr_n;
      state_r      <= state_n;
      s_ready_r    <= 1'b1;
      drop_r       <= drop_s;
      pending_r    <= pending_n;
      if (out_valid_s && m_axis_tready) begin
        rd_ptr_r <= rd_ptr_r + ONE_P;
      end
    end
  end

  assign s_axis_tready  = s_ready_r;
  assign m_axis_tdata   = rd_data_s;
  assign m_axis_tvalid  = out_valid_s;
  assign m_axis_tlast   = out_last_s;
  assign frame_dropped  = drop_r;
  assign frames_pending = pending_r;

`ifdef COBS_FRAME_FIFO_STATS_EN
  logic [15:0] committed_r;
  logic [15:0] discarded_r;

  // Saturating frame statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      committed_r <= 16'h0000;
      discarded_r <= 16'h0000;
    end else begin
      if (commit_s && (committed_r != 16'hFFFF)) begin
        committed_r <= committed_r + 16'h0001;
      end
      if (drop_s && (discarded_r != 16'hFFFF)) begin
        discarded_r <= discarded_r + 16'h0001;
      end
    end
  end

  assign frames_committed = committed_r;
  assign frames_discarded = discarded_r;
`else
  assign frames_committed = 16'h0000;
  assign frames_discarded = 16'h0000;
`endif

endmodule
